// File: rtl/uart_pkg.sv
// Shared types and constants for the IO-page UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_OVF       = 3;
    localparam int unsigned STAT_PARITY    = 4;
    localparam int unsigned STAT_COUNT_LSB = 8;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head output; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and status register.
// Define UART_PARITY_EN to insert an even-parity bit after the data bits.
module io_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1250,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioWrite,
    input  logic [31:0] addr,
    input  logic [31:0] memWdata,
    output logic [31:0] ioRdata,
    output logic        uartTx,
    output logic        txBusy
);

    localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
`ifdef UART_PARITY_EN
    localparam logic        PARITY_EN   = 1'b1;
`else
    localparam logic        PARITY_EN   = 1'b0;
`endif

    uart_state_e     state;
    logic [15:0]     baud;
    logic [2:0]      bitidx;
    logic [7:0]      shift;
`ifdef UART_PARITY_EN
    logic            parity_bit;
`endif

    logic [1:0]      reg_sel;
    logic            push;
    logic            pop;
    logic            ovf_clr;
    logic            overflow;
    logic [7:0]      head;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic [31:0]     status;
    logic            unused_bits;

    assign reg_sel     = addr[3:2];
    assign push        = ioWrite && (reg_sel == REG_TXDATA);
    assign ovf_clr     = ioWrite && (reg_sel == REG_STATUS) && memWdata[STAT_OVF];
    assign pop         = !empty && ((state == IDLE) || ((state == STOP) && (baud == '0)));
    assign txBusy      = (state != IDLE) || !empty;
    assign unused_bits = ^{addr[31:4], addr[1:0], memWdata[31:8]};

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (memWdata[7:0]),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            baud   <= '0;
            bitidx <= '0;
            shift  <= '0;
            uartTx <= 1'b1;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shift  <= head;
                        uartTx <= 1'b0;
                        baud   <= BAUD_RELOAD;
                        state  <= START;
`ifdef UART_PARITY_EN
                        parity_bit <= ^head;
`endif
                    end
                end
                START: begin
                    if (baud == '0) begin
                        baud   <= BAUD_RELOAD;
                        bitidx <= '0;
                        uartTx <= shift[0];
                        state  <= DATA;
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
                DATA: begin
                    if (baud == '0) begin
                        baud <= BAUD_RELOAD;
                        if (bitidx == 3'd7) begin
`ifdef UART_PARITY_EN
                            uartTx <= parity_bit;
                            state  <= PARITY;
`else
                            uartTx <= 1'b1;
                            state  <= STOP;
`endif
                        end else begin
                            shift  <= {1'b0, shift[7:1]};
                            bitidx <= bitidx + 3'd1;
                            uartTx <= shift[1];
                        end
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (baud == '0) begin
                        baud   <= BAUD_RELOAD;
                        uartTx <= 1'b1;
                        state  <= STOP;
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (baud == '0) begin
                        baud <= BAUD_RELOAD;
                        // Chain straight into the next start bit when data is waiting.
                        if (!empty) begin
                            shift  <= head;
                            uartTx <= 1'b0;
                            state  <= START;
`ifdef UART_PARITY_EN
                            parity_bit <= ^head;
`endif
                        end else begin
                            uartTx <= 1'b1;
                            state  <= IDLE;
                        end
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
                default: begin
                    uartTx <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        status                            = '0;
        status[STAT_BUSY]                 = txBusy;
        status[STAT_FULL]                 = full;
        status[STAT_EMPTY]                = empty;
        status[STAT_OVF]                  = overflow;
        status[STAT_PARITY]               = PARITY_EN;
        status[STAT_COUNT_LSB +: 8]       = 8'(count);
    end

    always_comb begin
        ioRdata = '0;
        if (reg_sel == REG_STATUS) begin
            ioRdata = status;
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed self-checking bench for io_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_io_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int          FB  = 11;
    localparam logic [31:0] PAR = 32'h10;
`else
    localparam int          FB  = 10;
    localparam logic [31:0] PAR = 32'h0;
`endif

    logic        clk;
    logic        reset;
    logic        ioWrite;
    logic [31:0] addr;
    logic [31:0] memWdata;
    logic [31:0] ioRdata;
    logic        uartTx;
    logic        txBusy;

    int checks = 0;
    int errors = 0;

    io_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ioWrite  (ioWrite),
        .addr     (addr),
        .memWdata (memWdata),
        .ioRdata  (ioRdata),
        .uartTx   (uartTx),
        .txBusy   (txBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for bit b of a frame (0 = start bit).
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (FB == 11 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        ioWrite = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic io_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ioWrite  = 1'b1;
        addr     = a;
        memWdata = d;
        @(negedge clk);
        ioWrite = 1'b0;
        addr    = 32'h0;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v    = ioRdata;
        addr = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        checks++;
        if (uartTx !== 1'b1 || txBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: uartTx=%b txBusy=%b expected 1 0", uartTx, txBusy);
        end
        read_reg(32'h4, v);
        checks++;
        if (v !== (32'h4 | PAR)) begin
            errors++;
            $display("FAIL reset_status: got %h expected %h", v, 32'h4 | PAR);
        end
        read_reg(32'h8000_1004, v);
        checks++;
        if (v !== (32'h4 | PAR)) begin
            errors++;
            $display("FAIL status_high_addr: got %h expected %h", v, 32'h4 | PAR);
        end
        read_reg(32'h0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL txdata_read: got %h expected 0", v);
        end
        read_reg(32'h8, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reserved2_read: got %h expected 0", v);
        end
        read_reg(32'hC, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reserved3_read: got %h expected 0", v);
        end
        // Reserved writes must not enqueue anything.
        io_write(32'h8, 32'h55);
        io_write(32'hC, 32'hAA);
        read_reg(32'h4, v);
        checks++;
        if (v !== (32'h4 | PAR) || txBusy !== 1'b0) begin
            errors++;
            $display("FAIL reserved_write: status=%h busy=%b expected %h 0", v, txBusy, 32'h4 | PAR);
        end
    endtask

    task automatic test_single();
        logic [31:0] v;
        logic        e;
        do_reset();
        io_write(32'h0, 32'hA5);
        checks++;
        if (uartTx !== 1'b1 || txBusy !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: uartTx=%b txBusy=%b expected 1 1", uartTx, txBusy);
        end
        for (int n = 1; n <= FB * CPB; n++) begin
            @(negedge clk);
            e = exp_bit(8'hA5, (n - 1) / CPB);
            checks++;
            if (uartTx !== e || txBusy !== 1'b1) begin
                errors++;
                $display("FAIL single_bit cycle %0d: uartTx=%b txBusy=%b expected %b 1",
                         n, uartTx, txBusy, e);
            end
            if (n == 20) begin
                read_reg(32'h4, v);
                checks++;
                if (v !== (32'h5 | PAR)) begin
                    errors++;
                    $display("FAIL single_status: got %h expected %h", v, 32'h5 | PAR);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (uartTx !== 1'b1 || txBusy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: uartTx=%b txBusy=%b expected 1 0", uartTx, txBusy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic        e;
        do_reset();
        @(negedge clk);
        ioWrite  = 1'b1;
        addr     = 32'h0;
        memWdata = 32'h55;
        @(negedge clk);
        memWdata = 32'h0F;
        @(negedge clk);
        ioWrite = 1'b0;
        read_reg(32'h4, v);
        checks++;
        if (v !== (32'h101 | PAR)) begin
            errors++;
            $display("FAIL b2b_status: got %h expected %h", v, 32'h101 | PAR);
        end
        for (int n = 1; n <= 2 * FB * CPB; n++) begin
            if (n > 1) @(negedge clk);
            if (n <= FB * CPB) e = exp_bit(8'h55, (n - 1) / CPB);
            else               e = exp_bit(8'h0F, (n - 1 - FB * CPB) / CPB);
            checks++;
            if (uartTx !== e || txBusy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_bit cycle %0d: uartTx=%b txBusy=%b expected %b 1",
                         n, uartTx, txBusy, e);
            end
        end
        @(negedge clk);
        checks++;
        if (uartTx !== 1'b1 || txBusy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: uartTx=%b txBusy=%b expected 1 0", uartTx, txBusy);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            ioWrite  = 1'b1;
            addr     = 32'h0;
            memWdata = 32'h10 + i;
            @(negedge clk);
        end
        ioWrite = 1'b0;
        read_reg(32'h4, v);
        checks++;
        if (v !== (32'h40B | PAR)) begin
            errors++;
            $display("FAIL ovf_set: got %h expected %h", v, 32'h40B | PAR);
        end
        io_write(32'h4, 32'h0);
        read_reg(32'h4, v);
        checks++;
        if (v !== (32'h40B | PAR)) begin
            errors++;
            $display("FAIL ovf_write0: got %h expected %h", v, 32'h40B | PAR);
        end
        io_write(32'h4, 32'h8);
        read_reg(32'h4, v);
        checks++;
        if (v !== (32'h403 | PAR)) begin
            errors++;
            $display("FAIL ovf_clear: got %h expected %h", v, 32'h403 | PAR);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        int          bad;
        do_reset();
        io_write(32'h0, 32'hFF);
        io_write(32'h0, 32'h00);
        repeat (8) @(negedge clk);
        checks++;
        if (txBusy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy: txBusy=%b expected 1", txBusy);
        end
        reset = 1'b1;
        @(negedge clk);
        read_reg(32'h4, v);
        checks++;
        if (uartTx !== 1'b1 || txBusy !== 1'b0 || v !== (32'h4 | PAR)) begin
            errors++;
            $display("FAIL midrst_state: uartTx=%b txBusy=%b status=%h expected 1 0 %h",
                     uartTx, txBusy, v, 32'h4 | PAR);
        end
        reset = 1'b0;
        bad   = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (uartTx !== 1'b1 || txBusy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_quiet: %0d active cycles expected 0", bad);
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [31:0] v;
        logic        e;
        do_reset();
        io_write(32'h0, 32'h07);
        for (int n = 1; n <= 44; n++) begin
            @(negedge clk);
            e = (n >= 37 && n <= 40) ? 1'b1 : exp_bit(8'h07, (n - 1) / CPB);
            checks++;
            if (uartTx !== e || txBusy !== 1'b1) begin
                errors++;
                $display("FAIL parity_bit cycle %0d: uartTx=%b txBusy=%b expected %b 1",
                         n, uartTx, txBusy, e);
            end
        end
        @(negedge clk);
        read_reg(32'h4, v);
        checks++;
        if (txBusy !== 1'b0 || v !== 32'h14) begin
            errors++;
            $display("FAIL parity_end: txBusy=%b status=%h expected 0 00000014", txBusy, v);
        end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        ioWrite  = 1'b0;
        addr     = 32'h0;
        memWdata = 32'h0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
